dmem_bridge: RTL and testbench

//  Data-memory bridge directly downstream of the single-cycle core. Takes the core's load/store request
//  (Addr_out, Data_out, dm_ctrl, mem_w) and drives a synchronous word-wide RAM with byte/half lane steering.

---
 rtl/dmem_bridge.sv | 170 +++++++++++++++++
 tb/tb_dmem_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// Data-memory bridge: core load/store to a word-wide synchronous RAM.
// Byte/half lane steering on stores, lane select plus extension on loads.
module dmem_bridge #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_ctrl,
  output logic              MIO_ready,
  output logic [31:0]       Data_in,
  output logic              misalign,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                we_q;
  logic                h_q;
  logic                b_q;
  logic                sgn_q;
  logic                mis_q;
  logic [1:0]          cnt_q;
  logic [31:0]         data_q;

  logic                in_h;
  logic                in_b;
  logic                in_mis;
  logic                rd_done;
  logic                issue;
  logic [7:0]          rd_b;
  logic [15:0]         rd_h;
  logic [31:0]         ld_val;
  logic [3:0]          lane_we;
  logic [31:0]         lane_wd;
  logic                unused_hi;

  assign unused_hi = ^req_addr[31:ADDR_W+2];

  // Decode access size and alignment of the incoming request
  always_comb begin
    in_h   = (req_ctrl == 3'b001) || (req_ctrl == 3'b010);
    in_b   = (req_ctrl == 3'b011) || (req_ctrl == 3'b100);
    in_mis = 1'b0;
    unique case (1'b1)
      in_b:    in_mis = 1'b0;
      in_h:    in_mis = req_addr[0];
      default: in_mis = |req_addr[1:0];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Misaligned accesses still spend the issue slot (with the RAM
  // gated off) so every non-load completes with the same latency.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = ISSUE;
      ISSUE:   state_nx = (we_q || mis_q) ? RESP : WAIT;
      WAIT:    if (cnt_q == CNT_LAST) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the request when it is accepted in IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      h_q     <= 1'b0;
      b_q     <= 1'b0;
      sgn_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      addr_q  <= req_addr[ADDR_W+1:0];
      wdata_q <= req_wdata;
      we_q    <= req_we;
      h_q     <= in_h;
      b_q     <= in_b;
      sgn_q   <= (req_ctrl == 3'b001) || (req_ctrl == 3'b011);
      mis_q   <= in_mis;
    end
  end

  // Read-latency counter, cleared at issue, counting through WAIT
  always_ff @(posedge clk) begin
    if (!reset)               cnt_q <= '0;
    else if (state == ISSUE)  cnt_q <= '0;
    else if (state == WAIT)   cnt_q <= cnt_q + 2'd1;
  end

  assign rd_done = (state == WAIT) && (cnt_q == CNT_LAST);

  // Select the addressed lane of the read word and extend it
  always_comb begin
    rd_b   = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    rd_h   = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    ld_val = ram_rdata;
    unique case (1'b1)
      b_q:     ld_val = {{24{sgn_q & rd_b[7]}}, rd_b};
      h_q:     ld_val = {{16{sgn_q & rd_h[15]}}, rd_h};
      default: ld_val = ram_rdata;
    endcase
  end

  // Load result register; only a completed load updates it
  always_ff @(posedge clk) begin
    if (!reset)       data_q <= '0;
    else if (rd_done) data_q <= ld_val;
  end

  // Byte-enable and replicated write data for stores
  always_comb begin
    lane_we = 4'b1111;
    lane_wd = wdata_q;
    unique case (1'b1)
      b_q: begin
        lane_we = 4'b0001 << addr_q[1:0];
        lane_wd = {4{wdata_q[7:0]}};
      end
      h_q: begin
        lane_we = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_we = 4'b1111;
        lane_wd = wdata_q;
      end
    endcase
  end

  // RAM port is live only in an aligned ISSUE cycle
  always_comb begin
    issue     = (state == ISSUE) && !mis_q;
    ram_en    = issue;
    ram_we    = (issue && we_q) ? lane_we : 4'b0000;
    ram_addr  = issue ? addr_q[ADDR_W+1:2] : '0;
    ram_wdata = (issue && we_q) ? lane_wd : '0;
    MIO_ready = (state == RESP);
    misalign  = (state == RESP) && mis_q;
    Data_in   = data_q;
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized bench for dmem_bridge against a byte-array memory model.
// Includes a latency-programmable RAM behind the bridge.
module tb_dmem_bridge;

  localparam int AW  = 10;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [2:0]    req_ctrl;
  logic          MIO_ready;
  logic [31:0]   Data_in;
  logic          misalign;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  int            n_chk = 0;
  int            n_fail = 0;
  logic          ram_clr;
  logic [31:0]   ram  [0:(1<<AW)-1];
  logic [31:0]   pipe [0:LAT-1];
  logic [7:0]    ref_mem [0:(4<<AW)-1];
  logic [31:0]   exp_data;

  always #5 clk = ~clk;

  dmem_bridge #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ctrl  (req_ctrl),
    .MIO_ready (MIO_ready),
    .Data_in   (Data_in),
    .misalign  (misalign),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  assign ram_rdata = pipe[LAT-1];

  // Synchronous RAM; read data is garbage except RD_LAT cycles after ram_en
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= '0;
      pipe[0] <= 32'hDEAD_BEEF;
    end else if (ram_en) begin
      pipe[0] <= ram[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end else begin
      pipe[0] <= 32'hDEAD_BEEF;
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] ctrl);
    int          nb;
    int          off;
    int          idx;
    int          seen;
    int          n_en;
    logic        mis;
    logic        sgn;
    logic [3:0]  we_seen;
    logic [31:0] wd_seen;
    logic [31:0] ad_seen;
    logic [31:0] exp_wd;
    longint      v;
    nb  = (ctrl == 3'd1 || ctrl == 3'd2) ? 2 :
          (ctrl == 3'd3 || ctrl == 3'd4) ? 1 : 4;
    sgn = (ctrl == 3'd1 || ctrl == 3'd3);
    off = int'(a[1:0]);
    idx = int'(a[AW+1:0]);
    mis = (nb == 4 && off != 0) || (nb == 2 && (off % 2) != 0);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_ctrl  = ctrl;
    @(posedge clk);
    seen = 0;
    n_en = 0;
    we_seen = '0;
    wd_seen = '0;
    ad_seen = '0;
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      @(negedge clk);
      if (ram_en) begin
        n_en++;
        we_seen = ram_we;
        wd_seen = ram_wdata;
        ad_seen = 32'(ram_addr);
      end
      if (MIO_ready) seen = k;
    end
    if (!mis) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[idx+i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++)
          v = v | (longint'(ref_mem[idx+i]) << (8*i));
        if (sgn && v[8*nb-1])
          v = v | ~((longint'(1) << (8*nb)) - 1);
        exp_data = v[31:0];
      end
    end
    check("latency", seen, (mis || we) ? 2 : 2 + LAT);
    check("ram_en_count", n_en, mis ? 0 : 1);
    check("misalign", 32'(misalign), 32'(mis));
    check("data_in", Data_in, exp_data);
    if (!mis) check("ram_addr", ad_seen, 32'(a[AW+1:2]));
    if (!mis && !we) check("ram_we_load", 32'(we_seen), 0);
    if (!mis && we) begin
      for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
      check("ram_we", 32'(we_seen), ((1 << nb) - 1) << off);
      check("ram_wdata", wd_seen, exp_wd);
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("ready_pulse", 32'(MIO_ready), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(MIO_ready), 0);
    check({tag, "_data"}, Data_in, 0);
    check({tag, "_mis"}, 32'(misalign), 0);
    check({tag, "_en"}, 32'(ram_en), 0);
    check({tag, "_we"}, 32'(ram_we), 0);
    check({tag, "_addr"}, 32'(ram_addr), 0);
    check({tag, "_wdata"}, ram_wdata, 0);
  endtask

  initial begin
    int          n_rdy;
    logic [31:0] a;
    reset     = 1'b0;
    ram_clr   = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_ctrl  = '0;
    exp_data  = '0;
    for (int i = 0; i < (4<<AW); i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset   = 1'b1;
    ram_clr = 1'b0;
    @(negedge clk);

    access(1'b1, 32'h10, 32'h1234_5678, 3'b000);
    access(1'b0, 32'h10, 32'h0, 3'b000);
    check("lw_value", Data_in, 32'h1234_5678);

    access(1'b1, 32'h4, 32'h0, 3'b000);
    access(1'b1, 32'h5, 32'h0000_00AB, 3'b011);
    access(1'b0, 32'h4, 32'h0, 3'b000);
    check("sb_value", Data_in, 32'h0000_AB00);

    access(1'b1, 32'h8, 32'h8001_FF80, 3'b000);
    access(1'b0, 32'h8, 32'h0, 3'b011);
    access(1'b0, 32'h8, 32'h0, 3'b100);
    access(1'b0, 32'hA, 32'h0, 3'b001);
    access(1'b0, 32'hA, 32'h0, 3'b010);
    check("lhu_value", Data_in, 32'h0000_8001);

    access(1'b0, 32'h2, 32'h0, 3'b000);
    access(1'b1, 32'h3, 32'h0000_FFFF, 3'b001);
    access(1'b0, 32'h0, 32'h0, 3'b000);

    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_ctrl  = 3'b000;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("abort");
    reset     = 1'b1;
    req_valid = 1'b0;
    exp_data  = '0;
    n_rdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (MIO_ready) n_rdy++;
    end
    check("abort_no_ready", n_rdy, 0);
    access(1'b0, 32'h10, 32'h0, 3'b000);
    check("after_abort", Data_in, 32'h1234_5678);

    for (int n = 0; n < 400; n++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
      access(1'($urandom_range(0, 1)), a, $urandom,
             3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
